// File: rtl/dfu_boot_pkg.sv
// Shared definitions for the DFU boot sequencer: FSM encoding, DFU idle code,
// counter widths and a small constant helper.
package dfu_boot_pkg;

   typedef enum logic [1:0] {
      ST_POR_HOLD = 2'd0,
      ST_WAIT     = 2'd1,
      ST_DFU      = 2'd2,
      ST_BOOT     = 2'd3
   } boot_state_t;

   localparam logic [7:0]  DFU_STATE_IDLE = 8'h02;
   localparam int unsigned TIMER_W        = 32;
   localparam int unsigned HOLD_W         = 32;
   localparam int unsigned LED_POS_W      = 4;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dfu_led_pattern.sv
// Status LED pattern generator: free-running prescaler, idle blink, cylon scan in
// DFU, all-on in BOOT. Output is registered and active-low.
module dfu_led_pattern
   import dfu_boot_pkg::*;
#(
   parameter int unsigned N_LED     = 4,
   parameter int unsigned BLINK_BIT = 21,
   parameter int unsigned SCAN_BIT  = 20
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  boot_state_t      i_state,
   output logic [N_LED-1:0] o_led
);

   localparam int unsigned         PRESC_W = max_u(BLINK_BIT, SCAN_BIT) + 1;
   localparam logic [LED_POS_W-1:0] POS_MAX = LED_POS_W'(N_LED - 1);
   localparam logic [LED_POS_W-1:0] POS_ONE = LED_POS_W'(1);

   logic [PRESC_W-1:0]   r_presc;
   logic                 r_scan_d;
   logic [LED_POS_W-1:0] r_pos;
   logic                 r_dir_up;
   logic [N_LED-1:0]     r_led;
   logic [N_LED-1:0]     w_pattern;
   logic                 w_step;

   // The scan bit's rising edge is detected synchronously; it is never used as a clock.
   assign w_step = r_presc[SCAN_BIT] & ~r_scan_d & (i_state == ST_DFU);

   // Prescaler and delayed scan bit for edge detection
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_presc  <= '0;
         r_scan_d <= 1'b0;
      end else begin
         r_presc  <= r_presc + PRESC_W'(1);
         r_scan_d <= r_presc[SCAN_BIT];
      end
   end

   // Cylon position bouncing between LED 0 and LED N_LED-1
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pos    <= '0;
         r_dir_up <= 1'b1;
      end else if (w_step && (N_LED > 1)) begin
         if (r_dir_up) begin
            if (r_pos == POS_MAX) begin
               r_pos    <= r_pos - POS_ONE;
               r_dir_up <= 1'b0;
            end else begin
               r_pos <= r_pos + POS_ONE;
            end
         end else if (r_pos == '0) begin
            r_pos    <= r_pos + POS_ONE;
            r_dir_up <= 1'b1;
         end else begin
            r_pos <= r_pos - POS_ONE;
         end
      end
   end

   // Active-high pattern source selected by sequencer state
   always_comb begin
      w_pattern = '0;
      case (i_state)
         ST_BOOT:              w_pattern = '1;
         ST_DFU:               w_pattern = N_LED'(1'b1) << r_pos;
         ST_POR_HOLD, ST_WAIT: w_pattern[0] = r_presc[BLINK_BIT];
         default:              w_pattern = '0;
      endcase
   end

   // Registered active-low drive
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_led <= '1;
      end else begin
         r_led <= ~w_pattern;
      end
   end

   assign o_led = r_led;

endmodule

// File: rtl/dfu_boot_sequencer.sv
// USB DFU boot sequencer: power-on USB core reset hold, then auto-boot timeout or DFU
// session, ending in a sticky boot request. Optional button via DFU_BOOT_BUTTON_EN.
module dfu_boot_sequencer
   import dfu_boot_pkg::*;
#(
   parameter int unsigned N_LED          = 4,
   parameter int unsigned CLK_HZ         = 12000000,
   parameter int unsigned BOOT_TIMEOUT_S = 5,
   parameter int unsigned RESET_CYCLES   = 65535,
   parameter int unsigned BLINK_BIT      = 21,
   parameter int unsigned SCAN_BIT       = 20
`ifdef DFU_BOOT_BUTTON_EN
   ,
   parameter int unsigned DEBOUNCE_CYCLES = 240000
`endif
) (
   input  logic             clk,
   input  logic             reset,
`ifdef DFU_BOOT_BUTTON_EN
   input  logic             boot_btn,
`endif
   input  logic [7:0]       dfu_state,
   input  logic             dfu_detach,
   output logic             usb_reset,
   output logic             boot_req,
   output logic             auto_boot,
   output logic [N_LED-1:0] led
);

   localparam logic [TIMER_W-1:0] BOOT_CYCLES = TIMER_W'(CLK_HZ * BOOT_TIMEOUT_S);
   localparam logic [HOLD_W-1:0]  HOLD_LOAD   = HOLD_W'(RESET_CYCLES);

   if ((BOOT_CYCLES <= HOLD_LOAD) || (N_LED == 0) || (N_LED > 16)) begin : g_param_check
      $error("dfu_boot_sequencer: need BOOT_CYCLES > RESET_CYCLES and N_LED in 1..16");
   end

   boot_state_t        r_state;
   logic [HOLD_W-1:0]  r_hold_cnt;
   logic [TIMER_W-1:0] r_boot_timer;
   logic               r_usb_reset;
   logic               r_boot_req;
   logic               r_auto_boot;
   logic               w_btn_level;
   logic               w_btn_rise;

`ifdef DFU_BOOT_BUTTON_EN
   localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);

   logic        r_btn_s1;
   logic        r_btn_s2;
   logic        r_btn_db;
   logic        r_btn_db_d;
   logic [31:0] r_db_cnt;

   // Two-flop synchroniser; debounced level flips only after DEBOUNCE_CYCLES differing cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         r_btn_s1   <= 1'b0;
         r_btn_s2   <= 1'b0;
         r_btn_db   <= 1'b0;
         r_btn_db_d <= 1'b0;
         r_db_cnt   <= '0;
      end else begin
         r_btn_s1   <= boot_btn;
         r_btn_s2   <= r_btn_s1;
         r_btn_db_d <= r_btn_db;
         if (r_btn_s2 == r_btn_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt >= DB_LAST) begin
            r_btn_db <= r_btn_s2;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 32'd1;
         end
      end
   end

   assign w_btn_level = r_btn_db;
   assign w_btn_rise  = r_btn_db & ~r_btn_db_d;
`else
   assign w_btn_level = 1'b0;
   assign w_btn_rise  = 1'b0;
`endif

   // Sequencer FSM with hold counter, saturating boot timer and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_POR_HOLD;
         r_hold_cnt   <= HOLD_LOAD;
         r_boot_timer <= BOOT_CYCLES;
         r_usb_reset  <= 1'b1;
         r_boot_req   <= 1'b0;
         r_auto_boot  <= 1'b1;
      end else begin
         if (r_boot_timer != '0) begin
            r_boot_timer <= r_boot_timer - 32'd1;
         end
         case (r_state)
            ST_POR_HOLD: begin
               if (r_hold_cnt != '0) begin
                  r_hold_cnt  <= r_hold_cnt - 32'd1;
                  r_usb_reset <= (r_hold_cnt > 32'd1);
               end else if (w_btn_level) begin
                  r_usb_reset <= 1'b0;
                  r_state     <= ST_DFU;
                  r_auto_boot <= 1'b0;
               end else begin
                  r_usb_reset <= 1'b0;
                  r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Detach outranks a simultaneous move into DFU
               if (dfu_detach || w_btn_rise || (r_boot_timer == '0)) begin
                  r_state     <= ST_BOOT;
                  r_boot_req  <= 1'b1;
                  r_auto_boot <= 1'b0;
               end else if (dfu_state > DFU_STATE_IDLE) begin
                  r_state     <= ST_DFU;
                  r_auto_boot <= 1'b0;
               end
            end
            ST_DFU: begin
               if (dfu_detach || w_btn_rise) begin
                  r_state    <= ST_BOOT;
                  r_boot_req <= 1'b1;
               end
            end
            ST_BOOT: begin
               r_boot_req <= 1'b1;
            end
            default: begin
               r_state     <= ST_POR_HOLD;
               r_hold_cnt  <= HOLD_LOAD;
               r_usb_reset <= 1'b1;
               r_boot_req  <= 1'b0;
               r_auto_boot <= 1'b1;
            end
         endcase
      end
   end

   dfu_led_pattern #(
      .N_LED     (N_LED),
      .BLINK_BIT (BLINK_BIT),
      .SCAN_BIT  (SCAN_BIT)
   ) u_led_pattern (
      .i_clk   (clk),
      .i_reset (reset),
      .i_state (r_state),
      .o_led   (led)
   );

   assign usb_reset = r_usb_reset;
   assign boot_req  = r_boot_req;
   assign auto_boot = r_auto_boot;

endmodule
